uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver: the next generation of `uart_rx`. It replaces the fixed one-bit-per-clock sampler with a baud divider and mid-bit sampling, and supports configurable data width, optional parity, and 1 or 2 stop bits. Received words go into an output FIFO with a pop handshake, and parity, framing and overrun errors are flagged. It sits between the serial pin and the bridge's UART-to-CAN packing logic.

## Interface
- `DATA_BITS`, 8, data bits per frame, 5–9.
- `CLKS_PER_BIT`, 16, clock cycles per bit period, even, ≥ 4.
- `PARITY_EN`, 0, 1 = a parity bit follows the data bits.
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even parity; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1, 1 or 2.
- `FIFO_DEPTH`, 4, output FIFO depth, power of 2, ≥ 2.

Ports:
- `clock`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Serial_in`  in  1  asynchronous serial line; idles high.
- `rd_en`  in  1  pops the FIFO head; ignored when the FIFO is empty.
- `uart_rx_data_bus`  out  DATA_BITS  FIFO head word (first-word fall-through).
- `uart_data_ready`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of words held.
- `parity_err`  out  1  one-cycle pulse; a frame was dropped for bad parity.
- `frame_err`  out  1  one-cycle pulse; a frame was dropped for a low stop bit.
- `overrun_err`  out  1  one-cycle pulse; a good frame was dropped because the FIFO was full.
- `statev`  out  1  receiver busy (FSM not in IDLE).

## Operation
- `Serial_in` passes through a 2-flop synchroniser. Both flops reset to 1. All FSM logic uses the synchronised value `rx_s`.
- FSM states and transitions:
  - IDLE: a start edge is `rx_s` = 0 while the previous `rx_s` was 1 (cycle E). On a start edge, go to START and clear the bit counter and shift register.
  - START: sample at E + CLKS_PER_BIT/2. If `rx_s` = 1, this is a false start: return to IDLE with no error. Otherwise go to DATA.
  - DATA: sample bit i at E + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT, LSB first, shifting into the data register. After bit DATA_BITS−1, go to PARITY if `PARITY_EN` = 1, else STOP.
  - PARITY: sample one bit period after the last data bit. The check is XOR(data, parity bit) = `PARITY_ODD`. The result is recorded; the frame is not aborted.
  - STOP: sample STOP_BITS stop bits, one bit period apart. A frame error occurs if any stop bit samples 0.
- At the last stop sample (cycle L), the FSM always returns to IDLE, so the next start edge can be detected from L+1.
- Frame outcome at cycle L, in priority order:
  1. Frame error: drop the word, pulse `frame_err` at L+1.
  2. Parity error: drop the word, pulse `parity_err` at L+1.
  3. FIFO full with no pop in the same cycle: drop the word, pulse `overrun_err` at L+1.
  4. Otherwise: push the word.
- After a frame error, a line held low does not start a new frame. A new frame needs `rx_s` to return to 1 and then fall again.
- FIFO is circular, with wr/rd pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH. `fifo_count` tracks occupancy.
- Push and pop in the same cycle: both happen and the count is unchanged. This holds even when the FIFO is full, so no overrun is raised.
- Pop when empty: ignored, pointers unchanged.

## Timing
- Reset values: FSM IDLE, `statev` 0, `uart_data_ready` 0, `fifo_count` 0, `uart_rx_data_bus` 0, all error pulses 0, pointers 0, synchroniser flops 1.
- Reset asserted mid-frame: the FSM returns to IDLE and the FIFO is emptied on the next clock edge. No error pulse is emitted.
- Pin to E: the `Serial_in` falling edge reaches E 2–3 cycles later (synchroniser plus edge register).
- E to L: L = E + CLKS_PER_BIT/2 + (DATA_BITS + PARITY_EN + STOP_BITS)·CLKS_PER_BIT. For 8N1 with CLKS_PER_BIT = 16, that is E + 152.
- The push is registered. `uart_data_ready`, `fifo_count` and `uart_rx_data_bus` update at L+1.
- Pop: the cycle after `rd_en` is sampled high, `uart_rx_data_bus` shows the next word and `fifo_count` has decremented.
- `statev` is high from E+1 through L and low at L+1.

## Test plan
- 8N1, CLKS_PER_BIT = 16: send 0x41 then 0x42 → `fifo_count` = 2, head = 0x41; pop → head = 0x42; pop → `uart_data_ready` = 0, no error pulses.
- Glitch: `Serial_in` low for 4 cycles → start sample reads 1, FSM returns to IDLE, FIFO empty, no errors.
- PARITY_EN = 1, even parity, 0x41 sent with parity bit 1 → `parity_err` pulses once, FIFO empty; resend with parity bit 0 → 0x41 pushed.
- STOP_BITS = 2, second stop bit driven 0 → `frame_err` pulse, word dropped; the next frame is received only after the line returns high.
- FIFO_DEPTH = 4: send 0x10–0x14 without popping → 4 words held, `overrun_err` pulses on 0x14; repeat with `rd_en` high at cycle L of 0x14 → word accepted, count stays 4.
- Assert `reset` low during data bit 3 → all outputs return to reset values next clock; a following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with baud divider, mid-bit sampling, optional parity, 1/2 stop bits
// and a first-word fall-through output FIFO with parity/framing/overrun flags.
module uart_rx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               Serial_in,
  input  logic                               rd_en,
  output logic [DATA_BITS-1:0]               uart_rx_data_bus,
  output logic                               uart_data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               parity_err,
  output logic                               frame_err,
  output logic                               overrun_err,
  output logic                               statev
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 sync1, rx_s, rx_prev;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bad, stop_bad;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        count;

  logic tick_full, frame_end, frame_bad, full, pop, push;

  assign tick_full = (clk_cnt == FULL_M1);
  assign frame_end = (state == STOP) && tick_full && (bit_cnt == LAST_STOP);
  // The final stop sample is still on rx_s at cycle L, so fold it in directly.
  assign frame_bad = stop_bad | ~rx_s;
  assign full      = (count == FULL_CNT);
  assign pop       = rd_en && (count != '0);
  assign push      = frame_end && !frame_bad && !parity_bad && (!full || pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_bad  <= 1'b0;
      stop_bad    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync1       <= Serial_in;
      rx_s        <= sync1;
      rx_prev     <= rx_s;
      parity_err  <= frame_end && !frame_bad && parity_bad;
      frame_err   <= frame_end && frame_bad;
      overrun_err <= frame_end && !frame_bad && !parity_bad && full && !pop;
      clk_cnt     <= clk_cnt + 1'b1;
      case (state)
        IDLE: begin
          // Requires a genuine 1->0 transition, so a line stuck low never restarts.
          if (!rx_s && rx_prev) begin
            state      <= START;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bad <= 1'b0;
            stop_bad   <= 1'b0;
          end
        end
        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_full) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick_full) begin
            clk_cnt    <= '0;
            parity_bad <= ((^shift) ^ rx_s) != ODD;
            state      <= STOP;
          end
        end
        STOP: begin
          if (tick_full) begin
            clk_cnt <= '0;
            if (!rx_s) stop_bad <= 1'b1;
            if (bit_cnt == LAST_STOP) state <= IDLE;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign uart_data_ready  = (count != '0);
  assign fifo_count       = count;
  assign uart_rx_data_bus = uart_data_ready ? mem[rd_ptr] : '0;
  assign statev           = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: an 8N1 instance and an 8E2 instance, both 16 clocks/bit, depth 4.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       ser0 = 1'b1, rd0 = 1'b0;
  logic [7:0] data0;
  logic       rdy0, pe0, fe0, oe0, st0;
  logic [2:0] cnt0;
  logic       ser1 = 1'b1, rd1 = 1'b0;
  logic [7:0] data1;
  logic       rdy1, pe1, fe1, oe1, st1;
  logic [2:0] cnt1;

  int checks = 0;
  int errors = 0;
  int pe0_n = 0, fe0_n = 0, oe0_n = 0, pe1_n = 0, fe1_n = 0, oe1_n = 0;

  uart_rx_fifo u0 (
    .clock(clk), .reset(rst_n), .Serial_in(ser0), .rd_en(rd0),
    .uart_rx_data_bus(data0), .uart_data_ready(rdy0), .fifo_count(cnt0),
    .parity_err(pe0), .frame_err(fe0), .overrun_err(oe0), .statev(st0)
  );

  uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clock(clk), .reset(rst_n), .Serial_in(ser1), .rd_en(rd1),
    .uart_rx_data_bus(data1), .uart_data_ready(rdy1), .fifo_count(cnt1),
    .parity_err(pe1), .frame_err(fe1), .overrun_err(oe1), .statev(st1)
  );

  // Error pulses are counted in cycles high, so a stretched pulse shows up too.
  always @(negedge clk) begin
    pe0_n += int'(pe0); fe0_n += int'(fe0); oe0_n += int'(oe0);
    pe1_n += int'(pe1); fe1_n += int'(fe1); oe1_n += int'(oe1);
  end

  // Both send tasks expect to be entered right after a falling clock edge.
  task automatic send0(input logic [7:0] d);
    $display("u0 send 0x%02h", d);
    ser0 = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser0 = d[i];
      repeat (16) @(negedge clk);
    end
    ser0 = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] d, input logic par, input logic stop2);
    $display("u1 send 0x%02h parity %0d stop2 %0d", d, par, stop2);
    ser1 = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser1 = d[i];
      repeat (16) @(negedge clk);
    end
    ser1 = par;
    repeat (16) @(negedge clk);
    ser1 = 1'b1;
    repeat (16) @(negedge clk);
    ser1 = stop2;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop0();
    $display("u0 pop head 0x%02h", data0);
    rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
  endtask

  task automatic pop1();
    $display("u1 pop head 0x%02h", data1);
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({st0, rdy0, cnt0, data0, pe0, fe0, oe0} !== 16'h0) begin
      errors++;
      $display("FAIL reset_u0: got %h expected 0", {st0, rdy0, cnt0, data0, pe0, fe0, oe0});
    end
    checks++;
    if ({st1, rdy1, cnt1, data1, pe1, fe1, oe1} !== 16'h0) begin
      errors++;
      $display("FAIL reset_u1: got %h expected 0", {st1, rdy1, cnt1, data1, pe1, fe1, oe1});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1();
    int e0;
    e0 = pe0_n + fe0_n + oe0_n;
    fork
      send0(8'h41);
      begin
        // Pin falls at N0; E ends at P3, so cycle L (E+152) spans N154.
        repeat (154) @(negedge clk);
        checks++;
        if ({st0, cnt0} !== {1'b1, 3'd0}) begin
          errors++;
          $display("FAIL cycle_L: statev/count got %b/%0d expected 1/0", st0, cnt0);
        end
        @(negedge clk);
        checks++;
        if ({st0, cnt0} !== {1'b0, 3'd1}) begin
          errors++;
          $display("FAIL cycle_L1: statev/count got %b/%0d expected 0/1", st0, cnt0);
        end
      end
    join
    send0(8'h42);
    repeat (5) @(negedge clk);
    checks++;
    if ({cnt0, data0} !== {3'd2, 8'h41}) begin
      errors++;
      $display("FAIL two_words: count/head got %0d/%h expected 2/41", cnt0, data0);
    end
    pop0();
    checks++;
    if ({cnt0, data0} !== {3'd1, 8'h42}) begin
      errors++;
      $display("FAIL pop1: count/head got %0d/%h expected 1/42", cnt0, data0);
    end
    pop0();
    checks++;
    if ({rdy0, cnt0, data0} !== 12'h0) begin
      errors++;
      $display("FAIL pop2: ready/count/head got %b/%0d/%h expected 0/0/00", rdy0, cnt0, data0);
    end
    checks++;
    if (pe0_n + fe0_n + oe0_n !== e0) begin
      errors++;
      $display("FAIL 8n1_errs: pulses got %0d expected %0d", pe0_n + fe0_n + oe0_n, e0);
    end
  endtask

  task automatic test_glitch();
    int e0;
    e0 = pe0_n + fe0_n + oe0_n;
    $display("u0 glitch 4 cycles");
    ser0 = 1'b0;
    repeat (4) @(negedge clk);
    ser0 = 1'b1;
    @(negedge clk);
    checks++;
    if (st0 !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy: statev got %b expected 1", st0);
    end
    repeat (40) @(negedge clk);
    checks++;
    if ({st0, rdy0, cnt0, pe0_n + fe0_n + oe0_n} !== {1'b0, 1'b0, 3'd0, e0}) begin
      errors++;
      $display("FAIL glitch_idle: statev/ready/count/pulses got %b/%b/%0d/%0d expected 0/0/0/%0d",
               st0, rdy0, cnt0, pe0_n + fe0_n + oe0_n, e0);
    end
  endtask

  task automatic test_parity();
    int p1;
    p1 = pe1_n;
    send1(8'h41, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if ({pe1_n - p1, cnt1} !== {32'd1, 3'd0}) begin
      errors++;
      $display("FAIL parity_bad: pulses/count got %0d/%0d expected 1/0", pe1_n - p1, cnt1);
    end
    send1(8'h41, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if ({pe1_n - p1, cnt1, data1} !== {32'd1, 3'd1, 8'h41}) begin
      errors++;
      $display("FAIL parity_good: pulses/count/head got %0d/%0d/%h expected 1/1/41",
               pe1_n - p1, cnt1, data1);
    end
    pop1();
  endtask

  task automatic test_frame();
    int f1;
    f1 = fe1_n;
    send1(8'h33, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    checks++;
    if ({fe1_n - f1, cnt1, st1} !== {32'd1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL frame_drop: pulses/count/statev got %0d/%0d/%b expected 1/0/0",
               fe1_n - f1, cnt1, st1);
    end
    ser1 = 1'b1;
    repeat (20) @(negedge clk);
    send1(8'h5A, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if ({fe1_n - f1, cnt1, data1} !== {32'd1, 3'd1, 8'h5A}) begin
      errors++;
      $display("FAIL frame_recover: pulses/count/head got %0d/%0d/%h expected 1/1/5a",
               fe1_n - f1, cnt1, data1);
    end
    pop1();
  endtask

  task automatic test_overrun();
    int o0;
    for (int i = 0; i < 4; i++) send0(8'h10 + 8'(i));
    o0 = oe0_n;
    send0(8'h14);
    repeat (5) @(negedge clk);
    checks++;
    if ({oe0_n - o0, cnt0, data0} !== {32'd1, 3'd4, 8'h10}) begin
      errors++;
      $display("FAIL overrun: pulses/count/head got %0d/%0d/%h expected 1/4/10",
               oe0_n - o0, cnt0, data0);
    end
    fork
      send0(8'h14);
      begin
        repeat (154) @(negedge clk);
        rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    checks++;
    if ({oe0_n - o0, cnt0, data0} !== {32'd1, 3'd4, 8'h11}) begin
      errors++;
      $display("FAIL full_push_pop: pulses/count/head got %0d/%0d/%h expected 1/4/11",
               oe0_n - o0, cnt0, data0);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (data0 !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d: head got %h expected %h", i, data0, 8'h10 + 8'(i));
      end
      pop0();
    end
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: ready got %b expected 0", rdy0);
    end
  endtask

  task automatic test_reset_midframe();
    int e0;
    send0(8'h77);
    repeat (5) @(negedge clk);
    $display("u0 reset during data bit 3");
    ser0 = 1'b0;
    repeat (16) @(negedge clk);
    ser0 = 1'b1;
    repeat (54) @(negedge clk);
    checks++;
    if ({st0, cnt0} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL pre_reset: statev/count got %b/%0d expected 1/1", st0, cnt0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({st0, rdy0, cnt0, data0, pe0, fe0, oe0} !== 16'h0) begin
      errors++;
      $display("FAIL midframe_reset: got %h expected 0", {st0, rdy0, cnt0, data0, pe0, fe0, oe0});
    end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    e0 = pe0_n + fe0_n + oe0_n;
    send0(8'h5A);
    repeat (5) @(negedge clk);
    checks++;
    if ({cnt0, data0, pe0_n + fe0_n + oe0_n} !== {3'd1, 8'h5A, e0}) begin
      errors++;
      $display("FAIL after_reset: count/head/pulses got %0d/%h/%0d expected 1/5a/%0d",
               cnt0, data0, pe0_n + fe0_n + oe0_n, e0);
    end
    pop0();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_8n1();
    test_glitch();
    test_parity();
    test_frame();
    test_overrun();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
